// File: rtl/compare_sequencer_if.sv
// Handshake and read-port bundle for compare_sequencer.
// The slave modport is the sequencer's view. The master modport is the
// view of the block that drives start/abort and serves the word reads.
interface compare_sequencer_if #(
  parameter int BUS_SIZE = 16,
  parameter int ADDR_W   = 2
);
  logic                start;
  logic                abort;
  logic                busy;
  logic                done;
  logic                equal;
  logic [ADDR_W-1:0]   mismatch_idx;
  logic                rd_req;
  logic [ADDR_W-1:0]   rd_addr;
  logic                rd_ack;
  logic [BUS_SIZE-1:0] rd_a;
  logic [BUS_SIZE-1:0] rd_b;

  modport slave (
    input  start, abort, rd_ack, rd_a, rd_b,
    output busy, done, equal, mismatch_idx, rd_req, rd_addr
  );

  modport master (
    output start, abort, rd_ack, rd_a, rd_b,
    input  busy, done, equal, mismatch_idx, rd_req, rd_addr
  );
endinterface

// File: rtl/compare_sequencer.sv
// Multi-word equality sequencer: fetches WORDS word pairs over a req/ack read
// port, compares each pair with one BUS_SIZE comparator, and exits on the
// first mismatch.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; equal/mismatch_idx hold the last result
// FETCH | requesting word idx; compare on rd_ack, abort cancels
// DONE  | one-cycle result-valid pulse, then back to IDLE
module compare_sequencer #(
  parameter int BUS_SIZE = 16,
  parameter int WORDS    = 4,
  parameter int ADDR_W   = 2
) (
  input logic              clk,
  input logic              rst,
  compare_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(WORDS - 1);

  state_t              state;
  logic [ADDR_W-1:0]   idx;
  logic                equal_q;
  logic [ADDR_W-1:0]   mism_q;
  logic [BUS_SIZE-1:0] same_bits;
  logic                word_eq;

  // Bitwise XNOR then AND-reduce: every bit position must match.
  assign same_bits = bus.rd_a ~^ bus.rd_b;
  assign word_eq   = &same_bits;

  // Sequencer state, word index and registered result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      equal_q <= 1'b0;
      mism_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            idx   <= '0;
            state <= FETCH;
          end
        end
        FETCH: begin
          // Abort wins over a same-cycle acknowledge.
          if (bus.abort) begin
            equal_q <= 1'b0;
            mism_q  <= idx;
            idx     <= '0;
            state   <= IDLE;
          end else if (bus.rd_ack) begin
            if (!word_eq) begin
              equal_q <= 1'b0;
              mism_q  <= idx;
              idx     <= '0;
              state   <= DONE;
            end else if (idx == LAST_IDX) begin
              equal_q <= 1'b1;
              mism_q  <= '0;
              idx     <= '0;
              state   <= DONE;
            end else begin
              idx <= idx + ADDR_W'(1);
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs are decodes of registered state only.
  assign bus.busy         = (state == FETCH) || (state == DONE);
  assign bus.done         = (state == DONE);
  assign bus.rd_req       = (state == FETCH);
  assign bus.rd_addr      = (state == FETCH) ? idx : '0;
  assign bus.equal        = equal_q;
  assign bus.mismatch_idx = mism_q;

endmodule

// File: tb/tb_compare_sequencer.sv
// Directed self-checking bench for compare_sequencer (BUS_SIZE=16, WORDS=4).
module tb_compare_sequencer;
  localparam int BUS_SIZE = 16;
  localparam int WORDS    = 4;
  localparam int ADDR_W   = 2;

  logic clk;
  logic rst;

  compare_sequencer_if #(.BUS_SIZE(BUS_SIZE), .ADDR_W(ADDR_W)) bus ();

  compare_sequencer #(.BUS_SIZE(BUS_SIZE), .WORDS(WORDS), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Word memory for both operands, served combinationally by address.
  logic [BUS_SIZE-1:0] mem_a [WORDS];
  logic [BUS_SIZE-1:0] mem_b [WORDS];
  assign bus.rd_a = mem_a[bus.rd_addr];
  assign bus.rd_b = mem_b[bus.rd_addr];

  // Responder: acknowledges after wait_cfg idle cycles of a pending request.
  int wait_cfg = 0;
  int wcnt;
  assign bus.rd_ack = bus.rd_req && (wcnt >= wait_cfg);
  always @(posedge clk or posedge rst) begin
    if (rst) wcnt <= 0;
    else if (!bus.rd_req || bus.rd_ack) wcnt <= 0;
    else wcnt <= wcnt + 1;
  end

  // Monitors: accepted addresses, address stability while waiting, word-3 requests.
  int   acc_q[$];
  int   unstable = 0;
  logic pend = 1'b0;
  logic [ADDR_W-1:0] pend_addr = '0;
  logic seen3 = 1'b0;
  always @(posedge clk) begin
    if (!rst) begin
      if (bus.rd_req && bus.rd_ack && !bus.abort) acc_q.push_back(int'(bus.rd_addr));
      if (pend && bus.rd_req && bus.rd_addr != pend_addr) unstable++;
      if (bus.rd_req && bus.rd_addr == 2'd3) seen3 = 1'b1;
      pend      = bus.rd_req && !bus.rd_ack;
      pend_addr = bus.rd_addr;
    end
  end

  task automatic load_equal();
    mem_a[0] = 16'h1234; mem_b[0] = 16'h1234;
    mem_a[1] = 16'hFFFF; mem_b[1] = 16'hFFFF;
    mem_a[2] = 16'h0000; mem_b[2] = 16'h0000;
    mem_a[3] = 16'h8001; mem_b[3] = 16'h8001;
  endtask

  // Pulse start for one cycle, then return the cycle index (1 = first cycle
  // after the sampling edge) in which done is seen, or -1 on timeout.
  task automatic run_cmp(input int budget, output int lat, output logic eq,
                         output logic [ADDR_W-1:0] mi);
    lat = -1; eq = 1'bx; mi = 'x;
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      if (bus.done) begin
        lat = c; eq = bus.equal; mi = bus.mismatch_idx;
        break;
      end
    end
  endtask

  int                lat;
  logic              eq;
  logic [ADDR_W-1:0] mi;
  int                done_q[$];
  logic              done_seen;

  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    load_equal();
    rst = 1'b1;
    #12;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_req", bus.rd_req, 0);
    chk("rst_addr", bus.rd_addr, 0);
    chk("rst_equal", bus.equal, 0);
    chk("rst_midx", bus.mismatch_idx, 0);
    @(negedge clk); rst = 1'b0;

    // Test 1: asynchronous reset in the middle of a slow fetch.
    wait_cfg = 5;
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("t1_req_before", bus.rd_req, 1);
    #2 rst = 1'b1;
    #1;
    chk("t1_req_async", bus.rd_req, 0);
    chk("t1_busy_async", bus.busy, 0);
    chk("t1_done_async", bus.done, 0);
    @(negedge clk); rst = 1'b0;
    chk("t1_addr_after", bus.rd_addr, 0);

    // Test 2: equal operands, ack tied high.
    wait_cfg = 0;
    acc_q.delete();
    run_cmp(40, lat, eq, mi);
    chk("t2_lat", lat, 5);
    chk("t2_equal", eq, 1);
    chk("t2_midx", mi, 0);
    chk("t2_nacc", acc_q.size(), 4);
    for (int i = 0; i < acc_q.size() && i < 4; i++) chk("t2_addr_seq", acc_q[i], i);
    @(negedge clk);
    chk("t2_done_one_cycle", bus.done, 0);
    chk("t2_idle_busy", bus.busy, 0);

    // Test 3: mismatch at word 2, word 3 never requested.
    mem_b[2] = 16'h00F1; mem_a[2] = 16'h00F0;
    acc_q.delete();
    seen3 = 1'b0;
    run_cmp(40, lat, eq, mi);
    chk("t3_lat", lat, 4);
    chk("t3_equal", eq, 0);
    chk("t3_midx", mi, 2);
    chk("t3_nacc", acc_q.size(), 3);
    @(negedge clk);
    chk("t3_no_word3", seen3, 0);
    chk("t3_hold_midx", bus.mismatch_idx, 2);

    // Test 4: three wait cycles per word.
    load_equal();
    wait_cfg = 3;
    unstable = 0;
    acc_q.delete();
    run_cmp(60, lat, eq, mi);
    chk("t4_lat", lat, 17);
    chk("t4_equal", eq, 1);
    chk("t4_midx", mi, 0);
    chk("t4_addr_stable", unstable, 0);
    chk("t4_nacc", acc_q.size(), 4);

    // Test 5: abort during word 1 with a same-cycle ack.
    wait_cfg = 0;
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    @(posedge clk); #1 bus.abort = 1'b1;
    @(negedge clk);
    chk("t5_addr_at_abort", bus.rd_addr, 1);
    chk("t5_ack_at_abort", bus.rd_ack, 1);
    @(posedge clk); #1 bus.abort = 1'b0;
    done_seen = 1'b0;
    @(negedge clk);
    chk("t5_busy", bus.busy, 0);
    chk("t5_equal", bus.equal, 0);
    chk("t5_midx", bus.mismatch_idx, 1);
    for (int c = 0; c < 6; c++) begin
      if (bus.done) done_seen = 1'b1;
      @(negedge clk);
    end
    chk("t5_no_done", done_seen, 0);
    chk("t5_still_idle", bus.rd_req, 0);

    // Test 6: start held high; a new comparison every WORDS+2 cycles.
    done_q.delete();
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk);
      if (bus.done) done_q.push_back(c);
      if (c == 6) chk("t6_idle_gap_req", bus.rd_req, 0);
      if (c == 5) chk("t6_busy_in_done", bus.busy, 1);
    end
    chk("t6_ndone", done_q.size(), 3);
    for (int i = 0; i < done_q.size() && i < 3; i++) chk("t6_done_cycle", done_q[i], 5 + 6 * i);
    #1 bus.start = 1'b0;
    begin
      int k = 0;
      while (bus.busy && k < 40) begin
        @(negedge clk);
        k++;
      end
      chk("t6_drain", bus.busy, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
